// File: rtl/count_sequencer.sv
// Shares one WIDTH-bit up-counter between two requesters.
// Round-robin grant, count 0..limit, then a tagged done pulse.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_limit,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_limit,
    output logic             req1_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] limit_r;
    logic             last_id;
    logic             grant0;
    logic             grant1;
    logic             accept0;
    logic             accept1;

    // On a tie the requester that did not own the last job wins.
    assign grant0 = req0_valid && (!req1_valid || last_id);
    assign grant1 = req1_valid && (!req0_valid || !last_id);

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        done       = 1'b0;
        done_id    = 1'b0;
        state_nx   = state;
        unique case (state)
            IDLE: begin
                req0_ready = !abort && grant0;
                req1_ready = !abort && grant1;
                if (req0_ready || req1_ready) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (count == limit_r) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = !abort;
                done_id  = !abort && owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            limit_r <= '0;
            owner   <= 1'b0;
            last_id <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (accept0) begin
                    limit_r <= req0_limit;
                    owner   <= 1'b0;
                    last_id <= 1'b0;
                    count   <= '0;
                end else if (accept1) begin
                    limit_r <= req1_limit;
                    owner   <= 1'b1;
                    last_id <= 1'b1;
                    count   <= '0;
                end
            end else if (abort) begin
                count <= '0;
            end else if (state == RUN && count != limit_r) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that shares one WIDTH-bit up-counter between two requesters. Each requester submits a terminal count over a valid/ready handshake. A round-robin arbiter grants the counter, runs it from 0 up to the requested limit, then pulses done tagged with the owner's ID. It sits in front of the counter datapath and is the only block that sequences it.

## Interface
- WIDTH, 4, counter and limit width in bits
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_limit  in  WIDTH  requester 0 terminal count, sampled on accept
- req0_ready  out  1  requester 0 job accepted this cycle when valid also high
- req1_valid  in  1  requester 1 has a job
- req1_limit  in  WIDTH  requester 1 terminal count
- req1_ready  out  1  requester 1 accept strobe
- abort  in  1  cancel the running job
- count  out  WIDTH  current counter value
- busy  out  1  high in RUN and DONE
- owner  out  1  ID of the current or most recent job owner
- done  out  1  one-cycle pulse when a job completes
- done_id  out  1  owner ID qualified by done

## Operation
- States:
  - IDLE: no job; waits for a valid request.
  - RUN: counter increments once per cycle.
  - DONE: one cycle; done is asserted.
- Internal registers: state, count, limit_r, owner, last_id.
- Reset (async, immediate) sets:
  - state = IDLE, count = 0, limit_r = 0, owner = 0, last_id = 1
  - busy = 0, done = 0, done_id = 0
  - req0_ready = req1_ready = 0
- Arbitration, combinational, only in IDLE with abort low:
  - Exactly one valid: that requester is granted.
  - Both valid: grant goes to ~last_id (round-robin). With last_id = 1 after reset, req0 wins the first tie.
- reqN_ready = (state == IDLE) && !abort && grant == N. At most one ready is high in any cycle.
- Accept (valid && ready at a clock edge):
  - limit_r <= reqN_limit, owner <= N, last_id <= N, count <= 0, state <= RUN.
- RUN:
  - If count == limit_r: state <= DONE, count holds.
  - Otherwise count <= count + 1. The counter never wraps, because count <= limit_r <= 2^WIDTH-1.
- DONE:
  - done = 1 and done_id = owner.
  - state <= IDLE.
- IDLE:
  - count holds the last final value until the next accept.
  - owner holds.
- A requester's valid must stay high until its ready. Its limit must be stable while valid is high.
- abort:
  - In RUN or DONE: next state IDLE, count <= 0, and no done pulse. If abort arrives in the DONE cycle, done is suppressed combinationally.
  - In IDLE: blocks acceptance and has no other effect.
- limit = 0 is legal: RUN lasts one cycle with count 0, then DONE.
- Outputs done, done_id and ready are combinational from state and inputs. count, owner and busy are registered.

## Timing
- Accept at edge E:
  - RUN starts after E with count = 0.
  - count = k after edge E+k.
  - DONE is entered at edge E+L+1; done is high for exactly the cycle after it.
  - IDLE is re-entered at edge E+L+2.
- Job latency from accept edge to done-high cycle is L+1 edges, i.e. done is visible L+2 cycles after the accept cycle.
- Minimum spacing between accepts is L+3 cycles, because one IDLE cycle is mandatory before the next grant.
- Reset asserted mid-job: all outputs go to their reset values immediately. The job is lost and no done is issued.
- New valids arriving during RUN/DONE wait; their ready stays low.

## Test plan
- Reset then single job:
  - Stimulus: rst pulse; req0_valid=1, limit=3.
  - Required: req0_ready high in the first IDLE cycle; count goes 0,1,2,3 on consecutive cycles, then holds 3 during DONE; done=1 and done_id=0 for exactly one cycle; busy high for 5 cycles.
- Tie arbitration:
  - Stimulus: req0 and req1 both valid continuously, limits 2 and 5.
  - Required: grants alternate req0, req1, req0 with one IDLE cycle between jobs; done_id sequence is 0, 1, 0.
- Zero limit:
  - Stimulus: req1 limit=0.
  - Required: one RUN cycle with count=0, then done=1 with done_id=1; busy high for 2 cycles.
- Abort mid-run:
  - Stimulus: req0 limit=15; abort=1 when count=6.
  - Required: next cycle state IDLE, count=0, busy=0; no done. With abort held high, req ready stays 0.
- Full-range count:
  - Stimulus: limit=15 (WIDTH=4).
  - Required: count reaches 15 without wrapping; done fires; count holds 15 in IDLE.
- Async reset mid-job:
  - Stimulus: rst asserted between clock edges at count=4.
  - Required: count=0, busy=0, done=0 immediately; after release, a req1/req0 tie grants req0.
